fifo_drain: RTL and testbench

Read-side controller for the team's 32-deep synchronous FIFO. It pulls words through the FIFO's `rd_en`/`data_out` port and re-presents them downstream as a valid/ready stream with a 2-entry output buffer. Reads are throttled near empty because the FIFO's status flags are registered and lag its true occupancy. It supports fixed-length bursts and a continuous mode ended by `stop`.

---
 rtl/fifo_drain.sv | 128 ++++++++++++
 tb/tb_fifo_drain.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// Read-side controller for the 32-deep synchronous FIFO: pops words and re-presents
// them as a valid/ready stream through a 2-entry skid buffer, throttling near empty.
module fifo_drain #(
  parameter int WIDTH  = 32,
  parameter int LEN_W  = 16,
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  input  logic             stop,
  output logic             busy,
  output logic             done,
  output logic [LEN_W-1:0] words_sent,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_data,
  input  logic             fifo_empty,
  input  logic             fifo_almost_empty,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  typedef enum logic [1:0] {IDLE, RUN, SETL, DONE} state_t;

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic             stop_seen;
  logic [CW-1:0]    settle_cnt;
  logic             inflight;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head_q, tail_q;

  logic       pop, stop_now, len_ok, credit_ok, issue_end, drain_done, finish;
  logic [1:0] occ_nxt;

  assign pop      = m_valid & m_ready;
  assign stop_now = stop_seen | stop;
  assign len_ok   = (len_q == '0) || (issued < len_q);
  // Reserve a slot for every word already requested so an unconditional capture always fits.
  assign credit_ok = ({1'b0, occ} + {2'b0, inflight}) <= (3'd1 + {2'b0, pop});

  assign fifo_rd_en = (state == RUN) & ~fifo_empty & ~stop_now & len_ok & credit_ok;

  assign occ_nxt    = occ + {1'b0, inflight} - {1'b0, pop};
  assign issue_end  = stop_now | ((len_q != '0) & (issued == len_q));
  assign drain_done = ~fifo_rd_en & ~inflight & (occ_nxt == 2'd0);
  assign finish     = issue_end & drain_done;

  assign busy    = (state == RUN) | (state == SETL);
  assign done    = (state == DONE);
  assign m_valid = (occ != 2'd0);
  assign m_data  = head_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      len_q      <= '0;
      issued     <= '0;
      stop_seen  <= 1'b0;
      settle_cnt <= '0;
      inflight   <= 1'b0;
      occ        <= 2'd0;
      head_q     <= '0;
      tail_q     <= '0;
      words_sent <= '0;
    end else begin
      inflight <= fifo_rd_en;

      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) head_q <= fifo_data;
          else             tail_q <= fifo_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) head_q <= fifo_data;
          else begin
            head_q <= tail_q;
            tail_q <= fifo_data;
          end
        end
        default: ;
      endcase

      if (pop)        words_sent <= words_sent + 1'b1;
      if (fifo_rd_en) issued     <= issued + 1'b1;

      case (state)
        IDLE: if (start) begin
          len_q      <= burst_len;
          issued     <= '0;
          words_sent <= '0;
          stop_seen  <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          if (stop) stop_seen <= 1'b1;
          if (finish) state <= DONE;
          else if (fifo_rd_en && fifo_almost_empty) begin
            settle_cnt <= CW'(SETTLE - 1);
            state      <= SETL;
          end
        end
        SETL: begin
          if (stop) stop_seen <= 1'b1;
          if (finish)                state <= DONE;
          else if (settle_cnt == '0) state <= RUN;
          else                       settle_cnt <= settle_cnt - CW'(1);
        end
        DONE: begin
          stop_seen <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: queue-based FIFO model, stream scoreboard, exact-timing vectors
// for the listed corner cases, and randomized bursts with random backpressure.
module tb_fifo_drain;
  localparam int WIDTH = 32, LEN_W = 16, SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst_n, start, stop, fifo_empty, fifo_almost_empty, m_ready;
  logic [LEN_W-1:0] burst_len;
  logic [WIDTH-1:0] fifo_data;
  logic             busy, done, fifo_rd_en, m_valid;
  logic [LEN_W-1:0] words_sent;
  logic [WIDTH-1:0] m_data;

  fifo_drain #(.WIDTH(WIDTH), .LEN_W(LEN_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .burst_len(burst_len), .stop(stop),
    .busy(busy), .done(done), .words_sent(words_sent), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    int          nwords;
    int          rlo;
    int          rhi;
    int          stop_cyc;
    logic [63:0] exp_rd;
    int          exp_done;
    int          exp_sent;
  } vec_t;

  int          checks = 0, errors = 0;
  logic [31:0] fq[$];
  logic [31:0] exp_q[$];
  int          seq = 0, cyc = 0;
  bit          xfer, stop_m, pend, prev_stall, push_en;
  int          len_m, nreads, nhs, done_cyc, sent_at_done, last_caut;
  logic [63:0] rd_mask;
  logic [31:0] pend_w, prev_data;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic upd_flags();
    fifo_empty        = (fq.size() == 0);
    fifo_almost_empty = (fq.size() <= 2);
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back({16'(seq), 16'($urandom)});
      seq++;
    end
    upd_flags();
  endtask

  task automatic model_reset();
    fq.delete();
    exp_q.delete();
    pend = 0; xfer = 0; stop_m = 0; nhs = 0; nreads = 0; len_m = 0;
    prev_stall = 0; push_en = 0;
    fifo_data = '0;
    upd_flags();
  endtask

  // One clock cycle: inputs are already set; check at the falling edge, then advance.
  task automatic step();
    bit acc;
    acc = 0;
    @(negedge clk);
    if (rst_n) begin
      if (fifo_rd_en) begin
        chk("rd_while_empty", fifo_empty, 0);
        chk("rd_without_busy", busy, 1);
        chk("rd_after_stop", stop_m || stop, 0);
        if (len_m != 0) chk("rd_over_len", nreads < len_m, 1);
        chk("settle_gap", (cyc - last_caut) > SETTLE, 1);
        if (fifo_almost_empty) last_caut = cyc;
        nreads++;
        if (cyc < 64) rd_mask[cyc] = 1'b1;
        if (fq.size() > 0) begin
          pend_w = fq.pop_front();
          exp_q.push_back(pend_w);
          pend = 1;
        end
      end
      if (xfer && stop) stop_m = 1;
      if (prev_stall) begin
        chk("stall_valid", m_valid, 1);
        chk("stall_data", m_data, prev_data);
      end
      chk("words_sent", words_sent, LEN_W'(nhs));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
        else                   chk("m_data", m_data, exp_q.pop_front());
        nhs++;
      end
      chk("outstanding", exp_q.size() <= 2, 1);
      if (done) begin
        done_cyc     = cyc;
        sent_at_done = nhs;
        chk("done_drained", exp_q.size(), 0);
        chk("done_busy", busy, 0);
        if (len_m != 0 && !stop_m) chk("done_len", nreads, len_m);
        xfer = 0; stop_m = 0;
      end else begin
        chk("busy", busy, xfer);
      end
      prev_stall = m_valid & ~m_ready;
      prev_data  = m_data;
      acc = start && !xfer && !done;
    end
    @(posedge clk); #1;
    cyc++;
    if (pend) begin
      fifo_data = pend_w;
      pend = 0;
    end
    if (acc) begin
      xfer = 1; nhs = 0; nreads = 0; stop_m = 0;
      len_m = int'(burst_len);
    end
    if (push_en && $urandom_range(0, 3) == 0) load(1);
    else                                      upd_flags();
  endtask

  task automatic run(input vec_t v, input bit rnd_ready, input bit push);
    rd_mask = '0; done_cyc = -1; last_caut = -100; cyc = 0;
    push_en = push;
    fq.delete();
    load(v.nwords);
    burst_len = LEN_W'(v.len);
    for (int c = 0; c < 400 && done_cyc < 0; c++) begin
      start   = (c == 0);
      stop    = (c == v.stop_cyc);
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : !(c >= v.rlo && c <= v.rhi);
      step();
    end
    start = 0; stop = 0; m_ready = 1;
    chk("timeout", done_cyc >= 0, 1);
    push_en = 0;
    step();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_words_sent"}, words_sent, 0);
    chk({tag, "_m_data"}, m_data, 0);
  endtask

  vec_t vecs[7];
  vec_t v;

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4, 10, -1, -1, -1, 64'h1E,   7, 4};  // basic burst
    vecs[1] = '{8, 20,  4,  9, -1, 64'h7C0E, 17, 8}; // backpressure
    vecs[2] = '{2,  2, -1, -1, -1, 64'h12,   7, 2};  // near empty, cautious reads
    vecs[3] = '{0, 32, -1, -1,  6, 64'h3E,   8, 5};  // continuous + stop
    vecs[4] = '{1, 10, -1, -1, -1, 64'h2,    4, 1};
    vecs[5] = '{3,  3, -1, -1, -1, 64'h26,   8, 3};  // fast then cautious
    vecs[6] = '{5, 10,  3,  4, -1, 64'hE6,  10, 5};

    rst_n = 0;
    start = 0; stop = 0; m_ready = 1; burst_len = '0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); stop = 1'($urandom); m_ready = 1'($urandom);
      burst_len = LEN_W'($urandom); fifo_data = $urandom;
      fifo_empty = 1'($urandom); fifo_almost_empty = 1'($urandom);
      @(negedge clk);
      chk_zero_outputs("reset");
      @(posedge clk); #1;
    end
    start = 0; stop = 0; m_ready = 1; burst_len = '0;
    model_reset();
    load(5);
    rst_n = 1;
    @(negedge clk);
    chk("post_reset_rd_en", fifo_rd_en, 0);
    chk("post_reset_busy", busy, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      run(vecs[i], 0, 0);
      chk($sformatf("vec%0d_rd_cycles", i), rd_mask, vecs[i].exp_rd);
      chk($sformatf("vec%0d_done_cycle", i), done_cyc, vecs[i].exp_done);
      chk($sformatf("vec%0d_sent", i), sent_at_done, vecs[i].exp_sent);
    end

    // Reset in cycle 3 of a burst of 8, then a clean burst of 8.
    fq.delete();
    load(20);
    burst_len = LEN_W'(8);
    cyc = 0; rd_mask = '0; last_caut = -100;
    for (int c = 0; c < 3; c++) begin
      start = (c == 0); stop = 0; m_ready = 1;
      step();
    end
    start = 0;
    rst_n = 0;
    #1;
    chk_zero_outputs("midrst");
    @(negedge clk);
    chk_zero_outputs("midrst_hold");
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    v = '{8, 20, -1, -1, -1, 64'h1FE, 11, 8};
    run(v, 0, 0);
    chk("after_rst_rd_cycles", rd_mask, v.exp_rd);
    chk("after_rst_done_cycle", done_cyc, v.exp_done);
    chk("after_rst_sent", sent_at_done, v.exp_sent);

    for (int i = 0; i < 12; i++) begin
      v.len = $urandom_range(0, 10);
      if (v.len == 0) v.stop_cyc = $urandom_range(3, 25);
      else            v.stop_cyc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 15)) : -1;
      v.nwords = $urandom_range(0, 8);
      v.rlo = -1; v.rhi = -1;
      run(v, 1, 1);
      chk($sformatf("rand%0d_sent_eq_reads", i), sent_at_done, nreads);
      if (v.stop_cyc < 0) chk($sformatf("rand%0d_sent_eq_len", i), sent_at_done, v.len);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
